// File: rtl/mult_issue_ctrl_if.sv
// rtl/mult_issue_ctrl_if.sv - operand, multiplier and result signal bundle for mult_issue_ctrl
interface mult_issue_ctrl_if #(
    parameter int WIDTH = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               mult_start;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic               mult_done;
    logic [2*WIDTH:0]   mult_product;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH:0]   out_product;

    // master: operand source, multiplier and result sink; slave: the controller
    modport master (
        output in_valid, in_a, in_b, mult_done, mult_product, out_ready,
        input  in_ready, mult_start, mult_a, mult_b, out_valid, out_product
    );
    modport slave (
        input  in_valid, in_a, in_b, mult_done, mult_product, out_ready,
        output in_ready, mult_start, mult_a, mult_b, out_valid, out_product
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - operand FIFO, single-issue sequencer and watchdog for shift_add_mult
module mult_issue_ctrl #(
    parameter int WIDTH   = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mult_issue_ctrl_if.slave       bus,
    output logic                   timeout_err,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 2 * WIDTH + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mult_a_q, mult_a_d;
    logic [WIDTH-1:0] mult_b_q, mult_b_d;
    logic             mult_start_q, mult_start_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    out_product_q, out_product_d;
    logic             timeout_err_q, timeout_err_d;
    logic             in_ready_w;
    logic             push;
    logic             pop;

    assign in_ready_w = (count_q != (AW+1)'(DEPTH));
    assign push       = bus.in_valid && in_ready_w;
    // A result still waiting downstream blocks the next issue
    assign pop        = (state_q == IDLE) && (count_q != '0) && !out_valid_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        mult_a_d      = mult_a_q;
        mult_b_d      = mult_b_q;
        mult_start_d  = 1'b0;
        wd_d          = wd_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        timeout_err_d = timeout_err_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    mult_a_d     = mem_a_q[rd_ptr_q];
                    mult_b_d     = mem_b_q[rd_ptr_q];
                    mult_start_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + WW'(1);
                // wd_q == 0 marks the first WAIT cycle, where done may be left over
                if ((wd_q != '0) && bus.mult_done) begin
                    out_product_d = bus.mult_product;
                    out_valid_d   = 1'b1;
                    state_d       = IDLE;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    out_product_d = '1;
                    out_valid_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= bus.in_a;
            mem_b_q[wr_ptr_q] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            mult_start_q  <= 1'b0;
            wd_q          <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            mult_start_q  <= mult_start_d;
            wd_q          <= wd_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.mult_start  = mult_start_q;
    assign bus.mult_a      = mult_a_q;
    assign bus.mult_b      = mult_b_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign timeout_err     = timeout_err_q;
    assign fifo_count      = count_q;
endmodule
